test_monitor: RTL and testbench

//  Synthesisable end-of-program monitor for the multi-cycle CPU test top.
//  - Watches fetch PC, halts the CPU via clock enable when PC hits TERM_PC.
//  - Then reads CHECK_COUNT data-memory words through a read port and compares each with an expected word.
//  - Reports terminal/correct and the first failing index; counts run cycles; optional watchdog.

---
 rtl/test_monitor.sv | 128 ++++++++++++
 tb/tb_test_monitor.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_monitor.sv
// test_monitor: end-of-program monitor for the multi-cycle CPU test top.
// Freezes the CPU (via cpu_run) once the fetch PC reaches TERM_PC, then walks
// CHECK_COUNT data-memory words through a synchronous read port and compares
// each against an expected-value table. The first mismatch stops the walk.
// Optional watchdog: define MONITOR_TIMEOUT_EN to end a run that never
// reaches TERM_PC within TIMEOUT run cycles.
module test_monitor #(
  parameter int              PC_W        = 32,
  parameter int              DATA_W      = 32,
  parameter int              ADDR_W      = 10,
  parameter logic [PC_W-1:0] TERM_PC     = PC_W'(32'h50),
  parameter int              CHECK_BASE  = 0,
  parameter int              CHECK_COUNT = 1,
  parameter int              IDX_W       = 8,
  parameter int              CNT_W       = 32,
  parameter int              TIMEOUT     = 100000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [PC_W-1:0]   pc,
  input  logic              pc_valid,
  output logic              cpu_run,
  output logic [ADDR_W-1:0] chk_addr,
  input  logic [DATA_W-1:0] chk_rdata,
  output logic [IDX_W-1:0]  chk_idx,
  input  logic [DATA_W-1:0] exp_data,
  output logic              terminal,
  output logic              correct,
  output logic              timed_out,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [1:0] {
    ST_RUN,   // CPU running, watching the fetch PC
    ST_ADDR,  // chk_addr on the read port, data arrives next cycle
    ST_CMP,   // chk_rdata valid for chk_idx, compare with exp_data
    ST_DONE   // verdict latched, everything frozen until reset
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHECK_COUNT - 1);

  // Elaboration-time sanity checks on the configuration.
  if (CHECK_COUNT < 1 || CHECK_COUNT > (1 << IDX_W)) begin : g_bad_check_count
    $error("test_monitor: CHECK_COUNT must be in 1..2**IDX_W");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("test_monitor: TIMEOUT must be positive");
  end

  state_t state;
  logic   pc_hit;

  // A fetch only counts as the terminating one when it is qualified.
  assign pc_hit = pc_valid && (pc == TERM_PC);

  // Word address for a given check index; wraps within the address space.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] idx);
    return ADDR_W'(CHECK_BASE) + ADDR_W'(idx);
  endfunction

`ifdef MONITOR_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
`else
  // Without the watchdog a run only ends on a PC match.
  assign timed_out = 1'b0;
`endif

  // Monitor state machine with all outputs registered.
  // NOTE: every register here uses <= so all of them sample the same
  // pre-edge values; a blocking = would let later lines see updated state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_RUN;
      cpu_run     <= 1'b1;
      chk_idx     <= '0;
      chk_addr    <= addr_of('0);
      terminal    <= 1'b0;
      correct     <= 1'b0;
      fail_idx    <= '0;
      cycle_count <= '0;
`ifdef MONITOR_TIMEOUT_EN
      timed_out   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_RUN: begin
          // cpu_run is 1 for the whole of RUN, so every RUN edge is a CPU edge,
          // including the one that samples the terminating PC.
          if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
          if (pc_hit) begin
            cpu_run <= 1'b0;
            state   <= ST_ADDR;
          end
`ifdef MONITOR_TIMEOUT_EN
          else if (cycle_count == TIMEOUT_LAST) begin
            cpu_run   <= 1'b0;
            timed_out <= 1'b1;
            terminal  <= 1'b1;
            correct   <= 1'b0;
            fail_idx  <= '1;
            state     <= ST_DONE;
          end
`endif
        end
        ST_ADDR: state <= ST_CMP;
        ST_CMP: begin
          if (chk_rdata != exp_data) begin
            fail_idx <= chk_idx;
            correct  <= 1'b0;
            terminal <= 1'b1;
            state    <= ST_DONE;
          end else if (chk_idx == LAST_IDX) begin
            correct  <= 1'b1;
            terminal <= 1'b1;
            state    <= ST_DONE;
          end else begin
            chk_idx  <= chk_idx + IDX_W'(1);
            chk_addr <= addr_of(chk_idx + IDX_W'(1));
            state    <= ST_ADDR;
          end
        end
        default: ;  // ST_DONE: registers hold their verdict
      endcase
    end
  end

endmodule

// File: tb/tb_test_monitor.sv
// tb_test_monitor: self-checking bench for test_monitor.
// Two monitors share clock, reset and PC: mon_a checks one word, mon_b checks
// four words with a short watchdog and a narrow cycle counter. Table-driven
// runs feed a result scoreboard and a chk_addr sequence scoreboard; hand
// sequences cover unqualified PCs, reset mid-check, DONE freeze and the
// watchdog (MONITOR_TIMEOUT_EN) or counter saturation (default build).
module tb_test_monitor;

  localparam logic [31:0] TERM = 32'h50;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] mem [4];
  logic [31:0] exp_tbl [4];

  logic        a_run, a_term, a_corr, a_to;
  logic [9:0]  a_addr;
  logic [7:0]  a_idx, a_fail;
  logic [31:0] a_rdata, a_exp, a_cnt;

  logic        b_run, b_term, b_corr, b_to;
  logic [9:0]  b_addr;
  logic [7:0]  b_idx, b_fail;
  logic [31:0] b_rdata, b_exp;
  logic [7:0]  b_cnt;

  always #5 clk = ~clk;

  // Synchronous-read data memory and combinational expected-value table.
  always @(posedge clk) begin
    a_rdata <= mem[a_addr[1:0]];
    b_rdata <= mem[b_addr[1:0]];
  end
  assign a_exp = exp_tbl[a_idx[1:0]];
  assign b_exp = exp_tbl[b_idx[1:0]];

  test_monitor #(.CHECK_COUNT(1)) mon_a (
    .clk(clk), .rstn(rstn), .pc(pc), .pc_valid(pc_valid), .cpu_run(a_run),
    .chk_addr(a_addr), .chk_rdata(a_rdata), .chk_idx(a_idx), .exp_data(a_exp),
    .terminal(a_term), .correct(a_corr), .timed_out(a_to), .fail_idx(a_fail),
    .cycle_count(a_cnt)
  );

  test_monitor #(.CHECK_COUNT(4), .TIMEOUT(16), .CNT_W(8)) mon_b (
    .clk(clk), .rstn(rstn), .pc(pc), .pc_valid(pc_valid), .cpu_run(b_run),
    .chk_addr(b_addr), .chk_rdata(b_rdata), .chk_idx(b_idx), .exp_data(b_exp),
    .terminal(b_term), .correct(b_corr), .timed_out(b_to), .fail_idx(b_fail),
    .cycle_count(b_cnt)
  );

  typedef struct {
    bit                sel_b;
    int                hit;
    logic [3:0][31:0]  mem_w;
    logic [3:0][31:0]  exp_w;
  } vec_t;

  typedef struct {
    logic        correct;
    logic [7:0]  fail_idx;
    logic [31:0] cnt;
    int          last;
    int          term_cycle;
  } exp_t;

  typedef struct packed {
    logic        run;
    logic [9:0]  addr;
    logic [7:0]  idx;
    logic        term;
    logic        corr;
    logic        to;
    logic [7:0]  fail;
    logic [31:0] cnt;
  } obs_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];
  int   addr_q [$];
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t observe(input bit sel_b);
    obs_t o;
    if (sel_b) begin
      o.run = b_run; o.addr = b_addr; o.idx = b_idx; o.term = b_term;
      o.corr = b_corr; o.to = b_to; o.fail = b_fail; o.cnt = 32'(b_cnt);
    end else begin
      o.run = a_run; o.addr = a_addr; o.idx = a_idx; o.term = a_term;
      o.corr = a_corr; o.to = a_to; o.fail = a_fail; o.cnt = a_cnt;
    end
    return o;
  endfunction

  function automatic vec_t mk(input bit sel_b, input int hit,
                              input logic [31:0] m0, m1, m2, m3,
                              input logic [31:0] e0, e1, e2, e3);
    vec_t v;
    v.sel_b = sel_b; v.hit = hit;
    v.mem_w[0] = m0; v.mem_w[1] = m1; v.mem_w[2] = m2; v.mem_w[3] = m3;
    v.exp_w[0] = e0; v.exp_w[1] = e1; v.exp_w[2] = e2; v.exp_w[3] = e3;
    return v;
  endfunction

  // Expected verdict: first mismatching word stops the walk; each checked
  // word costs two cycles after the one-cycle hop out of RUN.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    int   n;
    int   m;
    n = v.sel_b ? 4 : 1;
    m = n;
    for (int i = n - 1; i >= 0; i--)
      if (v.mem_w[i] !== v.exp_w[i]) m = i;
    e.correct    = (m == n);
    e.fail_idx   = (m == n) ? 8'd0 : 8'(m);
    e.last       = (m == n) ? n - 1 : m;
    e.term_cycle = v.hit + 2 * (e.last + 1) + 1;
    e.cnt        = 32'(v.hit);
    return e;
  endfunction

  // Leaves the bench at the start of cycle 1 after reset release.
  task automatic do_reset();
    rstn = 1'b0; pc_valid = 1'b0; pc = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // Fetches non-terminal PCs in cycles 1..hit-1 and TERM in cycle hit.
  task automatic run_to_hit(input int hit);
    for (int c = 1; c < hit; c++) begin
      pc = 32'h1000 + 32'(c); pc_valid = 1'b1;
      tick();
    end
    pc = TERM; pc_valid = 1'b1;
    tick();
  endtask

  task automatic run_vec(input vec_t v, input bit do_rst);
    exp_t       e;
    obs_t       o;
    int         cur;
    logic [9:0] prev;
    for (int i = 0; i < 4; i++) begin
      mem[i] = v.mem_w[i]; exp_tbl[i] = v.exp_w[i];
    end
    if (do_rst) do_reset();
    e = model(v);
    sb.push_back(e);
    for (int i = 1; i <= e.last; i++) addr_q.push_back(i);
    run_to_hit(v.hit);
    cur = v.hit + 1;
    o = observe(v.sel_b);
    check("cpu_run_after_hit", 32'(o.run), 32'd0);
    check("cycle_count_at_halt", o.cnt, 32'(v.hit));
    check("chk_addr_start", 32'(o.addr), 32'd0);
    prev = o.addr;
    while (!o.term && cur < v.hit + 40) begin
      tick();
      cur++;
      o = observe(v.sel_b);
      if (o.addr != prev) begin
        if (addr_q.size() > 0) check("chk_addr_seq", 32'(o.addr), 32'(addr_q.pop_front()));
        else check("chk_addr_extra", 32'(o.addr), 32'hFFFF_FFFF);
        prev = o.addr;
      end
    end
    if (!o.term) check("terminal_rise_timeout", 32'(o.term), 32'd1);
    e = sb.pop_front();
    check("terminal_cycle", 32'(cur), 32'(e.term_cycle));
    check("correct", 32'(o.corr), 32'(e.correct));
    check("fail_idx", 32'(o.fail), 32'(e.fail_idx));
    check("cycle_count", o.cnt, e.cnt);
    check("timed_out", 32'(o.to), 32'd0);
    check("cpu_run_done", 32'(o.run), 32'd0);
    check("chk_idx_final", 32'(o.idx), 32'(e.last));
    check("chk_addr_final", 32'(o.addr), 32'(e.last));
    check("chk_addr_seq_complete", 32'(addr_q.size()), 32'd0);
    addr_q.delete();
  endtask

  initial begin
    obs_t o;
    int   cur;
    vec_t vr;

    // Unmatched mem/exp words beyond the checked range must not matter for mon_a.
    vecs[0] = mk(0, 40, 32'h37, 32'h0, 32'h0, 32'h0, 32'h37, 32'h1, 32'h2, 32'h3);
    vecs[1] = mk(0, 40, 32'h36, 32'h0, 32'h0, 32'h0, 32'h37, 32'h0, 32'h0, 32'h0);
    vecs[2] = mk(1, 5,  32'h11, 32'h22, 32'h33, 32'h44, 32'h11, 32'h22, 32'h33, 32'h44);
    vecs[3] = mk(1, 6,  32'h11, 32'h22, 32'h99, 32'h44, 32'h11, 32'h22, 32'h33, 32'h44);
    vecs[4] = mk(1, 3,  32'h8000_0011, 32'h22, 32'h33, 32'h44, 32'h11, 32'h22, 32'h33, 32'h44);
    vecs[5] = mk(1, 9,  32'h11, 32'h22, 32'h33, 32'h45, 32'h11, 32'h22, 32'h33, 32'h44);
    vecs[6] = mk(0, 1,  32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);

    rstn = 1'b1; pc = '0; pc_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin mem[i] = '0; exp_tbl[i] = '0; end

    // Reset values on both monitors.
    #3 rstn = 1'b0;
    #4;
    for (int s = 0; s < 2; s++) begin
      o = observe(s[0]);
      check("rst_cpu_run", 32'(o.run), 32'd1);
      check("rst_terminal", 32'(o.term), 32'd0);
      check("rst_correct", 32'(o.corr), 32'd0);
      check("rst_timed_out", 32'(o.to), 32'd0);
      check("rst_chk_idx", 32'(o.idx), 32'd0);
      check("rst_chk_addr", 32'(o.addr), 32'd0);
      check("rst_fail_idx", 32'(o.fail), 32'd0);
      check("rst_cycle_count", o.cnt, 32'd0);
    end

    // Table-driven runs.
    for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b1);

    // DONE freeze: mon_a finished vecs[6] (pass, halted at cycle 1); scramble inputs.
    for (int c = 0; c < 10; c++) begin
      mem[0] = 32'h1234_0000 + 32'(c); exp_tbl[0] = 32'h5678_0000 + 32'(c);
      pc = c[0] ? TERM : 32'h3000; pc_valid = 1'b1;
      tick();
    end
    o = observe(1'b0);
    check("done_terminal", 32'(o.term), 32'd1);
    check("done_correct", 32'(o.corr), 32'd1);
    check("done_fail_idx", 32'(o.fail), 32'd0);
    check("done_cycle_count", o.cnt, 32'd1);
    check("done_cpu_run", 32'(o.run), 32'd0);

    // Unqualified terminating PC is ignored; a later qualified one halts.
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      pc = TERM; pc_valid = 1'b0;
      tick();
    end
    check("novalid_cpu_run", 32'(a_run), 32'd1);
    check("novalid_cycle_count", a_cnt, 32'd5);
    for (int c = 6; c <= 7; c++) begin
      pc = 32'h1000 + 32'(c); pc_valid = 1'b1;
      tick();
    end
    pc = TERM; pc_valid = 1'b1;
    tick();
    check("valid_hit_cpu_run", 32'(a_run), 32'd0);
    check("valid_hit_cycle_count", a_cnt, 32'd8);

    // Reset pulse during the compare of index 1, then a clean rerun from index 0.
    vr = mk(1, 4, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    for (int i = 0; i < 4; i++) begin mem[i] = vr.mem_w[i]; exp_tbl[i] = vr.exp_w[i]; end
    do_reset();
    run_to_hit(4);
    repeat (3) tick();
    check("midcheck_idx_before_reset", 32'(b_idx), 32'd1);
    #2 rstn = 1'b0;
    #1;
    o = observe(1'b1);
    check("midrst_cpu_run", 32'(o.run), 32'd1);
    check("midrst_terminal", 32'(o.term), 32'd0);
    check("midrst_chk_idx", 32'(o.idx), 32'd0);
    check("midrst_chk_addr", 32'(o.addr), 32'd0);
    check("midrst_cycle_count", o.cnt, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    run_vec(vr, 1'b0);

`ifdef MONITOR_TIMEOUT_EN
    // Watchdog fires on the 16th run edge when the PC never matches.
    do_reset();
    cur = 1;
    while (!b_term && cur < 60) begin
      pc = 32'h2000 + 32'(cur); pc_valid = 1'b1;
      tick();
      cur++;
    end
    check("wd_terminal_cycle", 32'(cur), 32'd17);
    check("wd_terminal", 32'(b_term), 32'd1);
    check("wd_timed_out", 32'(b_to), 32'd1);
    check("wd_correct", 32'(b_corr), 32'd0);
    check("wd_fail_idx", 32'(b_fail), 32'hFF);
    check("wd_cycle_count", 32'(b_cnt), 32'd16);
    check("wd_cpu_run", 32'(b_run), 32'd0);
    // A match on the timeout edge wins and checking proceeds.
    run_vec(mk(1, 16, 32'h5, 32'h6, 32'h7, 32'h8, 32'h5, 32'h6, 32'h7, 32'h8), 1'b1);
`else
    // No watchdog: a long unmatched run keeps going and the counter saturates.
    do_reset();
    for (int c = 1; c <= 300; c++) begin
      pc = 32'h2000 + 32'(c); pc_valid = 1'b1;
      tick();
    end
    check("nowd_terminal", 32'(b_term), 32'd0);
    check("nowd_timed_out", 32'(b_to), 32'd0);
    check("nowd_cpu_run", 32'(b_run), 32'd1);
    check("nowd_cycle_count_saturated", 32'(b_cnt), 32'd255);
    check("nowd_cycle_count_wide", a_cnt, 32'd300);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop should the stimulus ever stall.
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 1000000");
    $fatal(1);
  end

endmodule
